// File: rtl/lives_manager.sv
// ---------------------------------------------------------------------------
// lives_manager
//
// Tracks the player's remaining lives for a paddle/ball game and sequences
// the serve / play / respawn-wait / game-over flow.
//
// Configuration macro:
//   LIVES_BONUS_EN  defined   -> Bonus_Life adds a life (saturating) in PLAY
//                                or WAIT. A Ball_Lost and Bonus_Life in the
//                                same PLAY cycle cancel: Lives is unchanged
//                                and the FSM goes to WAIT.
//                   undefined -> Bonus_Life is accepted but has no effect.
//
// Parameters:
//   START_LIVES     lives loaded at reset and on New_Game (1..MAX_LIVES)
//   MAX_LIVES       saturation ceiling for Lives
//   RESPAWN_CYCLES  cycles spent in WAIT before the next serve
//   CNT_W           respawn counter width (must hold RESPAWN_CYCLES-1)
//
// Ports:
//   Clk          in   system clock, rising edge
//   Reset        in   asynchronous, active-high reset
//   New_Game     in   1-cycle pulse: (re)start the game, highest priority
//   Ball_Lost    in   1-cycle pulse: ball fell past the paddle
//   Bonus_Life   in   1-cycle pulse: extra life earned
//   Lives        out  current life count, 0..MAX_LIVES
//   Ball_Active  out  high while the ball is in play
//   Respawn      out  1-cycle pulse: serve a new ball
//   Game_Over    out  high once all lives are used up
//
// All outputs are registered. Respawn is high during the single SERVE cycle,
// which falls RESPAWN_CYCLES+1 cycles after the cycle in which Ball_Lost
// was sampled.
// ---------------------------------------------------------------------------
module lives_manager #(
  parameter int START_LIVES    = 3,
  parameter int MAX_LIVES      = 9,
  parameter int RESPAWN_CYCLES = 50000000,
  parameter int CNT_W          = 26
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       New_Game,
  input  logic       Ball_Lost,
  input  logic       Bonus_Life,
  output logic [7:0] Lives,
  output logic       Ball_Active,
  output logic       Respawn,
  output logic       Game_Over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_PLAY,
    S_WAIT,
    S_GAME_OVER
  } state_t;

  localparam logic [7:0]       START_L   = 8'(START_LIVES);
  localparam logic [7:0]       MAX_L     = 8'(MAX_LIVES);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RESPAWN_CYCLES - 1);

`ifdef LIVES_BONUS_EN
  localparam bit BONUS_EN = 1'b1;
`else
  localparam bit BONUS_EN = 1'b0;
`endif

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             bonus;
  logic [7:0]       lives_inc;

  // With the feature compiled out the pulse is simply masked, so every
  // downstream path behaves as if Bonus_Life never arrives.
  assign bonus = BONUS_EN && Bonus_Life;

  // NOTE: a combinational block must assign every output on every path
  // (here there is only one), otherwise synthesis infers a latch.
  always_comb begin
    lives_inc = (Lives >= MAX_L) ? MAX_L : Lives + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of statement
  // order inside the block.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      Lives       <= START_L;
      wait_cnt    <= '0;
      Ball_Active <= 1'b0;
      Respawn     <= 1'b0;
      Game_Over   <= 1'b0;
    end else begin
      // Respawn is a pulse: only the paths entering SERVE raise it.
      Respawn <= 1'b0;

      if (New_Game) begin
        state       <= S_SERVE;
        Lives       <= START_L;
        wait_cnt    <= '0;
        Respawn     <= 1'b1;
        Ball_Active <= 1'b0;
        Game_Over   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            // Waits for New_Game; outputs already hold their idle values.
          end

          S_SERVE: begin
            state       <= S_PLAY;
            Ball_Active <= 1'b1;
          end

          S_PLAY: begin
            if (Ball_Lost) begin
              Ball_Active <= 1'b0;
              if (bonus) begin
                // Loss and bonus cancel out; always go respawn.
                state    <= S_WAIT;
                wait_cnt <= '0;
              end else if (Lives > 8'd1) begin
                Lives    <= Lives - 8'd1;
                state    <= S_WAIT;
                wait_cnt <= '0;
              end else begin
                // Last life gone. Writing 0 rather than decrementing keeps
                // Lives from wrapping even if it were somehow already 0.
                Lives     <= 8'd0;
                state     <= S_GAME_OVER;
                Game_Over <= 1'b1;
              end
            end else if (bonus) begin
              Lives <= lives_inc;
            end
          end

          S_WAIT: begin
            // Ball_Lost is meaningless here: no ball is in play.
            if (bonus) begin
              Lives <= lives_inc;
            end
            if (wait_cnt == WAIT_LAST) begin
              state    <= S_SERVE;
              Respawn  <= 1'b1;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end

          S_GAME_OVER: begin
            // Terminal until New_Game; Ball_Lost and Bonus_Life ignored.
          end

          default: begin
            state       <= S_IDLE;
            Lives       <= START_L;
            wait_cnt    <= '0;
            Ball_Active <= 1'b0;
            Game_Over   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lives_manager.sv
// ---------------------------------------------------------------------------
// tb_lives_manager
//
// Self-checking bench for lives_manager with RESPAWN_CYCLES=4. A reference
// model tracks lives, whether a ball is in play, game-over, and the absolute
// cycle number at which the next Respawn pulse is due. Works with and
// without LIVES_BONUS_EN defined.
// ---------------------------------------------------------------------------
module tb_lives_manager;

  localparam int R     = 4;
  localparam int START = 3;
  localparam int MAXL  = 9;

`ifdef LIVES_BONUS_EN
  localparam bit BON = 1'b1;
`else
  localparam bit BON = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset;
  logic       New_Game;
  logic       Ball_Lost;
  logic       Bonus_Life;
  logic [7:0] Lives;
  logic       Ball_Active;
  logic       Respawn;
  logic       Game_Over;

  lives_manager #(
    .START_LIVES   (START),
    .MAX_LIVES     (MAXL),
    .RESPAWN_CYCLES(R),
    .CNT_W         (8)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .New_Game   (New_Game),
    .Ball_Lost  (Ball_Lost),
    .Bonus_Life (Bonus_Life),
    .Lives      (Lives),
    .Ball_Active(Ball_Active),
    .Respawn    (Respawn),
    .Game_Over  (Game_Over)
  );

  always #5 Clk = ~Clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int cyc        = 0;
  int m_lives    = START;
  bit m_active   = 1'b0;
  bit m_over     = 1'b0;
  int m_respawn_at = -1;

  localparam logic [10:0] IDLE_OUTS = {8'(START), 3'b000};

  function automatic logic [10:0] act();
    return {Lives, Ball_Active, Respawn, Game_Over};
  endfunction

  function automatic logic [10:0] expv();
    return {8'(m_lives), m_active, (m_respawn_at == cyc), m_over};
  endfunction

  function automatic void model_reset();
    m_lives      = START;
    m_active     = 1'b0;
    m_over       = 1'b0;
    m_respawn_at = -1;
  endfunction

  // One game rule step for the inputs sampled at the edge ending cycle cyc.
  function automatic void model_step(input bit ng, input bit bl, input bit bn);
    bit b;
    b = bn && BON;
    if (ng) begin
      m_lives      = START;
      m_over       = 1'b0;
      m_active     = 1'b0;
      m_respawn_at = cyc + 1;
    end else if (m_respawn_at == cyc) begin
      m_active     = 1'b1;
      m_respawn_at = -1;
    end else if (m_active) begin
      if (bl) begin
        m_active = 1'b0;
        if (!b) begin
          if (m_lives > 1) m_lives = m_lives - 1;
          else begin
            m_lives = 0;
            m_over  = 1'b1;
          end
        end
        if (!m_over) m_respawn_at = cyc + R + 1;
      end else if (b && m_lives < MAXL) begin
        m_lives = m_lives + 1;
      end
    end else if (m_respawn_at > cyc && b && m_lives < MAXL) begin
      m_lives = m_lives + 1;
    end
    cyc = cyc + 1;
  endfunction

  // Drive one cycle of pulses, advance the model, return at the next
  // falling edge with inputs cleared so outputs can be sampled.
  task automatic tick(input bit ng, input bit bl, input bit bn);
    New_Game   = ng;
    Ball_Lost  = bl;
    Bonus_Life = bn;
    @(posedge Clk);
    model_step(ng, bl, bn);
    @(negedge Clk);
    New_Game   = 1'b0;
    Ball_Lost  = 1'b0;
    Bonus_Life = 1'b0;
  endtask

  // Helper to build a "new game, enter play" prefix.
  function automatic void push_start(inout bit [2:0] s[$]);
    s.push_back(3'b100);
    s.push_back(3'b000);
  endfunction

  function automatic void push_loss(inout bit [2:0] s[$], input bit [2:0] code);
    s.push_back(code);
    repeat (R + 2) s.push_back(3'b000);
  endfunction

  task automatic test_reset();
    Reset      = 1'b1;
    New_Game   = 1'b1;
    Ball_Lost  = 1'b1;
    Bonus_Life = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      vectors++;
      if (act() !== IDLE_OUTS) begin
        miscompares++;
        $display("FAIL reset_hold i=%0d got %h exp %h", i, act(), IDLE_OUTS);
      end
    end
    New_Game   = 1'b0;
    Ball_Lost  = 1'b0;
    Bonus_Life = 1'b0;
    Reset      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      vectors++;
      if (act() !== expv()) begin
        miscompares++;
        $display("FAIL idle_ignore i=%0d got %h exp %h", i, act(), expv());
      end
    end
  endtask

  task automatic test_new_game_and_loss();
    int first = 0;
    tick(1'b1, 1'b0, 1'b0);
    vectors++;
    if (act() !== {8'(START), 3'b010}) begin
      miscompares++;
      $display("FAIL serve got %h exp %h", act(), {8'(START), 3'b010});
    end
    tick(1'b0, 1'b0, 1'b0);
    vectors++;
    if (act() !== {8'(START), 3'b100}) begin
      miscompares++;
      $display("FAIL play got %h exp %h", act(), {8'(START), 3'b100});
    end
    for (int n = 1; n <= 10; n++) begin
      tick(1'b0, n == 1, 1'b0);
      if (Respawn === 1'b1 && first == 0) first = n;
      vectors++;
      if (act() !== expv()) begin
        miscompares++;
        $display("FAIL loss_seq n=%0d got %h exp %h", n, act(), expv());
      end
    end
    vectors++;
    if (first !== R + 1) begin
      miscompares++;
      $display("FAIL respawn_latency got %0d exp %0d", first, R + 1);
    end
  endtask

  task automatic test_game_over();
    bit [2:0] s[$];
    push_start(s);
    repeat (3) push_loss(s, 3'b010);
    foreach (s[i]) begin
      tick(s[i][2], s[i][1], s[i][0]);
      vectors++;
      if (act() !== expv()) begin
        miscompares++;
        $display("FAIL game_over_seq i=%0d got %h exp %h", i, act(), expv());
      end
    end
    vectors++;
    if (act() !== 11'b0000_0000_001) begin
      miscompares++;
      $display("FAIL game_over_state got %h exp %h", act(), 11'b0000_0000_001);
    end
    s.delete();
    s.push_back(3'b010);
    s.push_back(3'b001);
    s.push_back(3'b011);
    s.push_back(3'b100);
    s.push_back(3'b000);
    foreach (s[i]) begin
      tick(s[i][2], s[i][1], s[i][0]);
      vectors++;
      if (act() !== expv()) begin
        miscompares++;
        $display("FAIL restart_seq i=%0d got %h exp %h", i, act(), expv());
      end
    end
    vectors++;
    if (act() !== {8'(START), 3'b100}) begin
      miscompares++;
      $display("FAIL restart_play got %h exp %h", act(), {8'(START), 3'b100});
    end
  endtask

  task automatic test_bonus();
    bit [2:0] s[$];
    logic [7:0] exp_l;
    push_start(s);
    repeat (9) s.push_back(3'b001);
    foreach (s[i]) begin
      tick(s[i][2], s[i][1], s[i][0]);
      vectors++;
      if (act() !== expv()) begin
        miscompares++;
        $display("FAIL bonus_seq i=%0d got %h exp %h", i, act(), expv());
      end
    end
    exp_l = BON ? 8'(MAXL) : 8'(START);
    vectors++;
    if (Lives !== exp_l) begin
      miscompares++;
      $display("FAIL bonus_saturate got %0d exp %0d", Lives, exp_l);
    end
    // Bring lives down to 1, then hit loss and bonus together.
    s.delete();
    push_start(s);
    repeat (2) push_loss(s, 3'b010);
    s.push_back(3'b011);
    foreach (s[i]) begin
      tick(s[i][2], s[i][1], s[i][0]);
      vectors++;
      if (act() !== expv()) begin
        miscompares++;
        $display("FAIL simul_seq i=%0d got %h exp %h", i, act(), expv());
      end
    end
    vectors++;
    if (act() !== (BON ? 11'b0000_0001_000 : 11'b0000_0000_001)) begin
      miscompares++;
      $display("FAIL simul_last_life got %h exp %h", act(),
               (BON ? 11'b0000_0001_000 : 11'b0000_0000_001));
    end
    // Bonus during WAIT, then watch the respawn.
    for (int i = 0; i < R + 3; i++) begin
      tick(1'b0, 1'b0, i == 1);
      vectors++;
      if (act() !== expv()) begin
        miscompares++;
        $display("FAIL wait_bonus i=%0d got %h exp %h", i, act(), expv());
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    bit [2:0] s[$];
    push_start(s);
    s.push_back(3'b010);
    s.push_back(3'b000);
    s.push_back(3'b000);
    foreach (s[i]) begin
      tick(s[i][2], s[i][1], s[i][0]);
      vectors++;
      if (act() !== expv()) begin
        miscompares++;
        $display("FAIL pre_reset i=%0d got %h exp %h", i, act(), expv());
      end
    end
    #2 Reset = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (act() !== IDLE_OUTS) begin
      miscompares++;
      $display("FAIL async_reset got %h exp %h", act(), IDLE_OUTS);
    end
    Ball_Lost = 1'b1;
    for (int i = 0; i < R + 2; i++) begin
      @(negedge Clk);
      vectors++;
      if (act() !== IDLE_OUTS) begin
        miscompares++;
        $display("FAIL reset_no_respawn i=%0d got %h exp %h", i, act(), IDLE_OUTS);
      end
    end
    Ball_Lost = 1'b0;
    Reset     = 1'b0;
    for (int i = 0; i < R + 3; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      vectors++;
      if (act() !== IDLE_OUTS) begin
        miscompares++;
        $display("FAIL post_reset_idle i=%0d got %h exp %h", i, act(), IDLE_OUTS);
      end
    end
  endtask

  task automatic test_priority();
    bit [2:0] s[$];
    push_start(s);
    s.push_back(3'b111);   // New_Game beats loss and bonus in PLAY
    s.push_back(3'b000);
    s.push_back(3'b010);
    s.push_back(3'b000);
    s.push_back(3'b100);   // New_Game mid-WAIT
    s.push_back(3'b100);   // New_Game in SERVE
    s.push_back(3'b000);
    foreach (s[i]) begin
      tick(s[i][2], s[i][1], s[i][0]);
      vectors++;
      if (act() !== expv()) begin
        miscompares++;
        $display("FAIL priority_seq i=%0d got %h exp %h", i, act(), expv());
      end
    end
  endtask

  task automatic test_random();
    bit ng, bl, bn;
    for (int i = 0; i < 800; i++) begin
      ng = ($urandom_range(0, 39) == 0);
      bl = ($urandom_range(0, 5) == 0);
      bn = ($urandom_range(0, 4) == 0);
      tick(ng, bl, bn);
      vectors++;
      if (act() !== expv()) begin
        miscompares++;
        $display("FAIL random i=%0d got %h exp %h", i, act(), expv());
      end
    end
  endtask

  initial begin
    Reset      = 1'b1;
    New_Game   = 1'b0;
    Ball_Lost  = 1'b0;
    Bonus_Life = 1'b0;
    @(negedge Clk);
    test_reset();
    test_new_game_and_loss();
    test_game_over();
    test_bonus();
    test_reset_mid_wait();
    test_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
